// File: rtl/lcd_hd44780_ctrl_if.sv
// Write-request channel from the display-content logic into the LCD controller.
// A request is held on wr_valid until the controller accepts it with wr_ready.
interface lcd_hd44780_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_is_cmd;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_is_cmd, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_is_cmd, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 controller: self-run power-on init, then one char/command per accepted request.
// A write holds wr_ready low for 3*CLK_DIV (6*CLK_DIV in 4-bit mode) plus the post-write wait.
module lcd_hd44780_ctrl #(
  parameter int CLK_DIV    = 2500,
  parameter int BUS_WIDTH  = 8,
  parameter int LINES      = 2,
  parameter int COLS       = 16,
  parameter int INIT_WAIT  = 750000,
  parameter int CMD_WAIT   = 2000,
  parameter int CLEAR_WAIT = 82000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  lcd_hd44780_ctrl_if.slave        wr_if,
  output logic                     init_done_o,
  output logic                     cursor_row_o,
  output logic [5:0]               cursor_col_o,
  output logic                     lcd_rs_o,
  output logic                     lcd_rw_o,
  output logic                     lcd_e_o,
  output logic [7:0]               lcd_data_o
);

  localparam bit          NIB     = (BUS_WIDTH == 4);
  localparam logic [7:0]  FUNCSET = 8'h20 | ((BUS_WIDTH == 8) ? 8'h10 : 8'h00)
                                          | ((LINES == 2) ? 8'h08 : 8'h00);
  localparam logic [3:0]  N_WAKE  = NIB ? 4'd4 : 4'd3;
  localparam logic [3:0]  N_INIT  = N_WAKE + 4'd4;
  localparam logic [31:0] DIV_M1  = 32'(CLK_DIV - 1);
  localparam logic [31:0] RST_CNT = 32'((INIT_WAIT > 1) ? INIT_WAIT - 2 : 0);

  typedef enum logic [2:0] {RESET_WAIT, INIT, IDLE, SETUP, E_HIGH, HOLD, WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        nib_only_q, nib_only_d;
  logic        lo_nib_q, lo_nib_d;
  logic        wake_q, wake_d;
  logic        wrap_q, wrap_d;
  logic [3:0]  init_step_q, init_step_d;
  logic        init_done_q, init_done_d;
  logic        row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [7:0]  lcd_data_q, lcd_data_d;

  logic        load;
  logic [7:0]  ld_byte;
  logic        ld_rs, ld_nib, ld_wake;
  logic [31:0] wait_m1;

  // Wake-up writes in both modes are 0x30 (only the high nibble reaches the pins in 4-bit mode).
  function automatic logic [7:0] init_byte(input logic [3:0] step);
    logic [7:0] b;
    b = 8'h06;
    if (step < 4'd3)                 b = 8'h30;
    else if (step < N_WAKE)          b = 8'h20;
    else if (step == N_WAKE)         b = FUNCSET;
    else if (step == N_WAKE + 4'd1)  b = 8'h0C;
    else if (step == N_WAKE + 4'd2)  b = 8'h01;
    return b;
  endfunction

  function automatic logic [7:0] bus_val(input logic [7:0] b, input logic lo);
    if (!NIB) return b;
    return lo ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
  endfunction

  assign wait_m1 = (wake_q || (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)))
                   ? 32'(CLEAR_WAIT - 1) : 32'(CMD_WAIT - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1;
    byte_d      = byte_q;
    rs_d        = rs_q;
    nib_only_d  = nib_only_q;
    lo_nib_d    = lo_nib_q;
    wake_d      = wake_q;
    wrap_d      = wrap_q;
    init_step_d = init_step_q;
    init_done_d = init_done_q;
    row_d       = row_q;
    col_d       = col_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    load        = 1'b0;
    ld_byte     = init_byte(init_step_q);
    ld_rs       = 1'b0;
    ld_nib      = NIB && (init_step_q < N_WAKE);
    ld_wake     = (init_step_q < 4'd3);

    case (state_q)
      RESET_WAIT: if (cnt_q == 32'd0) state_d = INIT;
      INIT: begin
        load        = 1'b1;
        init_step_d = init_step_q + 4'd1;
      end
      IDLE: if (wr_if.wr_valid && init_done_q) begin
        load    = 1'b1;
        ld_byte = wr_if.wr_data;
        ld_rs   = !wr_if.wr_is_cmd;
        ld_nib  = 1'b0;
        ld_wake = 1'b0;
      end
      SETUP: if (cnt_q == 32'd0) begin
        state_d = E_HIGH;
        cnt_d   = DIV_M1;
      end
      E_HIGH: if (cnt_q == 32'd0) begin
        state_d = HOLD;
        cnt_d   = DIV_M1;
      end
      HOLD: if (cnt_q == 32'd0) begin
        if (NIB && !nib_only_q && !lo_nib_q) begin
          state_d  = SETUP;
          cnt_d    = DIV_M1;
          lo_nib_d = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = wait_m1;
          if (rs_q) begin
            if (col_q == 6'(COLS - 1)) begin
              col_d  = 6'd0;
              row_d  = (LINES == 2) ? !row_q : 1'b0;
              wrap_d = 1'b1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end else if (byte_q == 8'h01 || byte_q == 8'h02) begin
            row_d = 1'b0;
            col_d = 6'd0;
          end else if (byte_q[7]) begin
            row_d = (LINES == 2) && byte_q[6];
            col_d = byte_q[5:0];
          end
        end
      end
      WAIT: if (cnt_q == 32'd0) begin
        if (wrap_q) begin
          load    = 1'b1;
          ld_byte = 8'h80 | {1'b0, row_q, 6'd0};
          ld_nib  = 1'b0;
          ld_wake = 1'b0;
          wrap_d  = 1'b0;
        end else if (!init_done_q) begin
          if (init_step_q == N_INIT) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            load        = 1'b1;
            init_step_d = init_step_q + 4'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = RESET_WAIT;
    endcase

    if (load) begin
      state_d    = SETUP;
      cnt_d      = DIV_M1;
      byte_d     = ld_byte;
      rs_d       = ld_rs;
      nib_only_d = ld_nib;
      wake_d     = ld_wake;
      lo_nib_d   = 1'b0;
    end

    // Pins change only on entry to SETUP so they stay put through E and between transfers.
    if (state_d == SETUP && state_q != SETUP) begin
      lcd_data_d = bus_val(byte_d, lo_nib_d);
      lcd_rs_d   = rs_d;
    end
    lcd_e_d = (state_d == E_HIGH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RESET_WAIT;
      cnt_q       <= RST_CNT;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      nib_only_q  <= 1'b0;
      lo_nib_q    <= 1'b0;
      wake_q      <= 1'b0;
      wrap_q      <= 1'b0;
      init_step_q <= 4'd0;
      init_done_q <= 1'b0;
      row_q       <= 1'b0;
      col_q       <= 6'd0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      nib_only_q  <= nib_only_d;
      lo_nib_q    <= lo_nib_d;
      wake_q      <= wake_d;
      wrap_q      <= wrap_d;
      init_step_q <= init_step_d;
      init_done_q <= init_done_d;
      row_q       <= row_d;
      col_q       <= col_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
    end
  end

  assign wr_if.wr_ready = (state_q == IDLE) && init_done_q;
  assign init_done_o    = init_done_q;
  assign cursor_row_o   = row_q;
  assign cursor_col_o   = col_q;
  assign lcd_rs_o       = lcd_rs_q;
  assign lcd_rw_o       = 1'b0;
  assign lcd_e_o        = lcd_e_q;
  assign lcd_data_o     = lcd_data_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench: 8-bit and 4-bit controllers side by side, init sequences, timing,
// cursor wrap, command cursor effects, hold-off during init and mid-pulse reset.
module tb_lcd_hd44780_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_hd44780_ctrl_if if8 ();
  lcd_hd44780_ctrl_if if4 ();

  logic       init_done8, row8, rs8, rw8, e8;
  logic [5:0] col8;
  logic [7:0] data8;
  logic       init_done4, row4, rs4, rw4, e4;
  logic [5:0] col4;
  logic [7:0] data4;

  lcd_hd44780_ctrl #(.CLK_DIV(2), .BUS_WIDTH(8), .LINES(2), .COLS(4), .INIT_WAIT(20),
                     .CMD_WAIT(5), .CLEAR_WAIT(10)) dut8 (
    .clk_i(clk), .rst_i(rst), .wr_if(if8), .init_done_o(init_done8),
    .cursor_row_o(row8), .cursor_col_o(col8), .lcd_rs_o(rs8), .lcd_rw_o(rw8),
    .lcd_e_o(e8), .lcd_data_o(data8));

  lcd_hd44780_ctrl #(.CLK_DIV(2), .BUS_WIDTH(4), .LINES(2), .COLS(4), .INIT_WAIT(20),
                     .CMD_WAIT(5), .CLEAR_WAIT(10)) dut4 (
    .clk_i(clk), .rst_i(rst), .wr_if(if4), .init_done_o(init_done4),
    .cursor_row_o(row4), .cursor_col_o(col4), .lcd_rs_o(rs4), .lcd_rw_o(rw4),
    .lcd_e_o(e4), .lcd_data_o(data4));

  int checks = 0;
  int failures = 0;
  int unstable = 0;

  logic [8:0] p8[$];
  logic [8:0] p4[$];
  logic       e8_prev = 1'b0, e4_prev = 1'b0;
  logic [8:0] hold8 = '0, hold4 = '0;

  logic [8:0] exp_init8 [7]  = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h00C, 9'h001, 9'h006};
  logic [8:0] exp_init4 [12] = '{9'h030, 9'h030, 9'h030, 9'h020, 9'h020, 9'h080,
                                 9'h000, 9'h0C0, 9'h000, 9'h010, 9'h000, 9'h060};

  // Each E pulse is logged as {rs, data} at its first high sample.
  always @(negedge clk) begin
    if (e8 && !e8_prev) begin
      p8.push_back({rs8, data8});
      hold8 = {rs8, data8};
    end else if (e8 && e8_prev && {rs8, data8} !== hold8) begin
      unstable++;
    end
    if (e4 && !e4_prev) begin
      p4.push_back({rs4, data4});
      hold4 = {rs4, data4};
    end else if (e4 && e4_prev && {rs4, data4} !== hold4) begin
      unstable++;
    end
    e8_prev = e8;
    e4_prev = e4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_init8(input string pfx);
    int n;
    n = 0;
    while (!init_done8 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({pfx, "_done"}, init_done8, 1);
    chk({pfx, "_count"}, p8.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("%s_byte%0d", pfx, i), (i < p8.size()) ? p8[i] : 9'h1FF, exp_init8[i]);
    chk({pfx, "_ready"}, if8.wr_ready, 1);
    chk({pfx, "_cursor"}, {row8, col8}, 0);
  endtask

  task automatic xfer8(input logic cmd, input logic [7:0] d,
                       output int e_first, output int e_last, output int rdy_at);
    int n;
    @(negedge clk);
    if8.wr_is_cmd = cmd;
    if8.wr_data   = d;
    if8.wr_valid  = 1'b1;
    n = 0;
    while (!if8.wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    if8.wr_valid = 1'b0;
    e_first = -1;
    e_last  = -1;
    rdy_at  = -1;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clk);
      if (e8) begin
        if (e_first < 0) e_first = c;
        e_last = c;
      end
      if (if8.wr_ready) begin
        rdy_at = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int ef, el, ra, n;
    if8.wr_valid = 1'b0; if8.wr_is_cmd = 1'b0; if8.wr_data = 8'h00;
    if4.wr_valid = 1'b1; if4.wr_is_cmd = 1'b0; if4.wr_data = 8'h5A;

    repeat (3) @(negedge clk);
    chk("rst_e8", e8, 0);
    chk("rst_outs8", {rs8, rw8, data8, if8.wr_ready, init_done8, row8, col8}, 0);
    chk("rst_outs4", {e4, rs4, rw4, data4, if4.wr_ready, init_done4, row4, col4}, 0);
    rst = 1'b0;

    check_init8("init8");

    n = 0;
    while (!init_done4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("init4_count", p4.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("init4_nib%0d", i), (i < p4.size()) ? p4[i] : 9'h1FF, exp_init4[i]);
    chk("holdoff_ready4", if4.wr_ready, 1);

    // Request held since reset is accepted on the first IDLE edge.
    p4.delete();
    @(posedge clk);
    @(negedge clk);
    if4.wr_valid = 1'b0;
    ra = -1;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clk);
      if (if4.wr_ready) begin
        ra = c;
        break;
      end
    end
    chk("char4_ready_at", ra, 18);
    chk("char4_count", p4.size(), 2);
    chk("char4_hi", (p4.size() > 0) ? p4[0] : 9'h1FF, 9'h150);
    chk("char4_lo", (p4.size() > 1) ? p4[1] : 9'h1FF, 9'h1A0);
    chk("char4_cursor", {row4, col4}, {1'b0, 6'd1});

    p8.delete();
    xfer8(1'b0, 8'h41, ef, el, ra);
    chk("char41_e_first", ef, 3);
    chk("char41_e_last", el, 4);
    chk("char41_ready_at", ra, 12);
    chk("char41_bus", (p8.size() > 0) ? p8[0] : 9'h1FF, 9'h141);
    chk("char41_cursor", {row8, col8}, {1'b0, 6'd1});

    xfer8(1'b0, 8'h42, ef, el, ra);
    xfer8(1'b0, 8'h43, ef, el, ra);
    p8.delete();
    xfer8(1'b0, 8'h44, ef, el, ra);
    chk("wrap0_ready_at", ra, 23);
    chk("wrap0_count", p8.size(), 2);
    chk("wrap0_ddram", (p8.size() > 1) ? p8[1] : 9'h1FF, 9'h0C0);
    chk("wrap0_cursor", {row8, col8}, {1'b1, 6'd0});

    xfer8(1'b0, 8'h45, ef, el, ra);
    chk("row1_cursor", {row8, col8}, {1'b1, 6'd1});
    xfer8(1'b0, 8'h46, ef, el, ra);
    xfer8(1'b0, 8'h47, ef, el, ra);
    p8.delete();
    xfer8(1'b0, 8'h48, ef, el, ra);
    chk("wrap1_ddram", (p8.size() > 1) ? p8[1] : 9'h1FF, 9'h080);
    chk("wrap1_cursor", {row8, col8}, 0);

    p8.delete();
    xfer8(1'b1, 8'hC2, ef, el, ra);
    chk("cmdC2_bus", (p8.size() > 0) ? p8[0] : 9'h1FF, 9'h0C2);
    chk("cmdC2_ready_at", ra, 12);
    chk("cmdC2_cursor", {row8, col8}, {1'b1, 6'd2});

    xfer8(1'b1, 8'h0C, ef, el, ra);
    chk("cmd0C_ready_at", ra, 12);
    chk("cmd0C_cursor", {row8, col8}, {1'b1, 6'd2});

    p8.delete();
    xfer8(1'b1, 8'h01, ef, el, ra);
    chk("cmd01_bus", (p8.size() > 0) ? p8[0] : 9'h1FF, 9'h001);
    chk("cmd01_ready_at", ra, 17);
    chk("cmd01_cursor", {row8, col8}, 0);

    xfer8(1'b0, 8'h41, ef, el, ra);
    chk("pre_rst_cursor", {row8, col8}, {1'b0, 6'd1});

    @(negedge clk);
    if8.wr_is_cmd = 1'b0;
    if8.wr_data   = 8'h42;
    if8.wr_valid  = 1'b1;
    n = 0;
    while (!e8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_e_high", e8, 1);
    if8.wr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_e_low", e8, 0);
    chk("mid_rst_outs8", {rs8, rw8, data8, if8.wr_ready, init_done8, row8, col8}, 0);
    p8.delete();
    p4.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_init8("reinit8");

    chk("e_stable", unstable, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
